// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types and constants for the synctimer subsystem: time type, adjust-sign
// encoding and the fractional-step split helper.
package jellyvl_synctimer_pkg;

    localparam int unsigned TIME_WIDTH = 64;
    typedef logic [TIME_WIDTH-1:0] t_time;

    localparam logic ADJ_SIGN_PLUS  = 1'b0;
    localparam logic ADJ_SIGN_MINUS = 1'b1;

    typedef struct packed {
        logic [31:0] step_int;
        logic [31:0] step_frac;
    } t_step;

    // Splits NUMERATOR/DENOMINATOR into integer and remainder parts; a zero
    // denominator yields zeros so elaboration can report it instead of dividing.
    function automatic t_step calc_step(input int unsigned numerator, input int unsigned denominator);
        t_step s;
        s = '0;
        if (denominator != 0) begin
            s.step_int  = numerator / denominator;
            s.step_frac = numerator % denominator;
        end
        return s;
    endfunction

endpackage

// File: rtl/jellyvl_synctimer_frac_step.sv
// Fractional-rate accumulator: adds STEP_FRAC per clock and raises carry on the
// cycle the sum reaches DENOMINATOR. clear zeroes the accumulator.
module jellyvl_synctimer_frac_step
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned DENOMINATOR = 3,
    parameter int unsigned STEP_FRAC   = 1,
    parameter int unsigned ACC_WIDTH   = 32
) (
    input  logic reset,
    input  logic clk,
    input  logic clear,
    output logic carry
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] acc_sum;

    // carry is combinational from the current accumulator so the caller can
    // fold it into the same edge's update.
    always_comb begin
        acc_sum = acc_q + ACC_WIDTH'(STEP_FRAC);
        carry   = (acc_sum >= ACC_WIDTH'(DENOMINATOR));
        acc_d   = carry ? (acc_sum - ACC_WIDTH'(DENOMINATOR)) : acc_sum;
        if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// Synctimer local time base: fractional nominal step, +/-1 slew on accepted adjust
// beats, hard load on set_valid. Optional counters under JELLYVL_SYNCTIMER_TIMER_MONITOR_EN.
module jellyvl_synctimer_timer
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned NUMERATOR   = 10,
    parameter int unsigned DENOMINATOR = 3,
    parameter int unsigned ACC_WIDTH   = 32
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic [TIMER_WIDTH-1:0] set_time,
    input  logic                   set_valid,
    input  logic                   adjust_sign,
    input  logic                   adjust_valid,
    output logic                   adjust_ready,
    output logic [TIMER_WIDTH-1:0] local_time,
    output logic [31:0]            mon_adjust_plus,
    output logic [31:0]            mon_adjust_minus
);

    localparam t_step       STEP      = calc_step(NUMERATOR, DENOMINATOR);
    localparam int unsigned STEP_INT  = STEP.step_int;
    localparam int unsigned STEP_FRAC = STEP.step_frac;

    if (DENOMINATOR < 1) begin : g_bad_den
        $error("jellyvl_synctimer_timer: DENOMINATOR must be >= 1");
    end
    if (NUMERATOR < DENOMINATOR) begin : g_bad_num
        $error("jellyvl_synctimer_timer: NUMERATOR must be >= DENOMINATOR");
    end

    // Handshake: a beat transfers on a clk edge where adjust_valid & adjust_ready.
    // adjust_ready drops combinationally during set_valid; the producer keeps
    // adjust_valid and adjust_sign stable until the beat transfers.
    logic                   ready_en_q;
    logic [TIMER_WIDTH-1:0] local_time_q;
    logic [TIMER_WIDTH-1:0] local_time_d;
    logic                   carry;
    logic                   adj_accept;
    logic                   adj_plus;
    logic                   adj_minus;

    assign adjust_ready = ready_en_q & ~set_valid;
    assign adj_accept   = adjust_valid & adjust_ready;
    assign adj_plus     = adj_accept & (adjust_sign == ADJ_SIGN_PLUS);
    assign adj_minus    = adj_accept & (adjust_sign == ADJ_SIGN_MINUS);
    assign local_time   = local_time_q;

    jellyvl_synctimer_frac_step #(
        .DENOMINATOR (DENOMINATOR),
        .STEP_FRAC   (STEP_FRAC),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_frac_step (
        .reset (reset),
        .clk   (clk),
        .clear (set_valid),
        .carry (carry)
    );

    // STEP_INT >= 1 makes the total increment non-negative even on a retard beat.
    always_comb begin
        local_time_d = local_time_q + TIMER_WIDTH'(STEP_INT) + TIMER_WIDTH'(carry)
                     + TIMER_WIDTH'(adj_plus) - TIMER_WIDTH'(adj_minus);
        if (set_valid) begin
            local_time_d = set_time;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q   <= 1'b0;
            local_time_q <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            local_time_q <= local_time_d;
        end
    end

`ifdef JELLYVL_SYNCTIMER_TIMER_MONITOR_EN
    logic [31:0] mon_plus_q;
    logic [31:0] mon_minus_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mon_plus_q  <= '0;
            mon_minus_q <= '0;
        end else if (set_valid) begin
            mon_plus_q  <= '0;
            mon_minus_q <= '0;
        end else begin
            if (adj_plus && (mon_plus_q != '1)) begin
                mon_plus_q <= mon_plus_q + 32'd1;
            end
            if (adj_minus && (mon_minus_q != '1)) begin
                mon_minus_q <= mon_minus_q + 32'd1;
            end
        end
    end

    assign mon_adjust_plus  = mon_plus_q;
    assign mon_adjust_minus = mon_minus_q;
`else
    assign mon_adjust_plus  = '0;
    assign mon_adjust_minus = '0;
`endif

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Self-checking bench for jellyvl_synctimer_timer: directed scenarios plus random
// traffic, checked against an arithmetic time model through an expected queue.
module tb_jellyvl_synctimer_timer;

    localparam int unsigned NUM = 10;
    localparam int unsigned DEN = 3;
    localparam int          W   = 1 + 64 + 32 + 32;

    logic        clk;
    logic        reset;
    logic [63:0] set_time;
    logic        set_valid;
    logic        adjust_sign;
    logic        adjust_valid;
    logic        adjust_ready;
    logic [63:0] local_time;
    logic [31:0] mon_adjust_plus;
    logic [31:0] mon_adjust_minus;

    jellyvl_synctimer_timer #(
        .TIMER_WIDTH (64),
        .NUMERATOR   (NUM),
        .DENOMINATOR (DEN),
        .ACC_WIDTH   (32)
    ) dut (
        .reset            (reset),
        .clk              (clk),
        .set_time         (set_time),
        .set_valid        (set_valid),
        .adjust_sign      (adjust_sign),
        .adjust_valid     (adjust_valid),
        .adjust_ready     (adjust_ready),
        .local_time       (local_time),
        .mon_adjust_plus  (mon_adjust_plus),
        .mon_adjust_minus (mon_adjust_minus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // time = base + floor(k * NUM / DEN) + net_adjust, modulo 2^64, where k counts
    // nominal edges since the last reset or load.
    longint unsigned m_base;
    longint unsigned m_k;
    longint unsigned m_adj;
    bit              m_armed;
    int unsigned     m_plus;
    int unsigned     m_minus;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [W-1:0] exp_q[$];

    function automatic longint unsigned model_time();
        return m_base + (m_k * NUM) / DEN + m_adj;
    endfunction

    task automatic model_reset();
        m_base  = 0;
        m_k     = 0;
        m_adj   = 0;
        m_armed = 0;
        m_plus  = 0;
        m_minus = 0;
    endtask

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: records the expected pre-edge outputs, drives the
    // inputs for the coming edge, then advances the model across that edge.
    task automatic step(input bit sv, input longint unsigned st, input bit av, input bit as);
        bit exp_ready;
        bit accepted;
        logic [31:0] ep;
        logic [31:0] em;
        exp_ready = m_armed && !sv;
`ifdef JELLYVL_SYNCTIMER_TIMER_MONITOR_EN
        ep = m_plus;
        em = m_minus;
`else
        ep = 32'd0;
        em = 32'd0;
`endif
        exp_q.push_back({exp_ready, model_time(), ep, em});
        set_valid    = sv;
        set_time     = st;
        adjust_valid = av;
        adjust_sign  = as;
        accepted     = av && exp_ready;
        if (sv) begin
            m_base  = st;
            m_k     = 0;
            m_adj   = 0;
            m_plus  = 0;
            m_minus = 0;
        end else begin
            m_k++;
            if (accepted) begin
                if (as) begin
                    m_adj = m_adj - 1;
                    if (m_minus != 32'hFFFF_FFFF) m_minus++;
                end else begin
                    m_adj = m_adj + 1;
                    if (m_plus != 32'hFFFF_FFFF) m_plus++;
                end
            end
        end
        m_armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Asserts reset between edges and checks the immediate effect directly.
    task automatic async_reset();
        set_valid    = 0;
        adjust_valid = 0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_time", local_time, 0);
        check("async_rst_ready", adjust_ready, 0);
        check("async_rst_mon_plus", mon_adjust_plus, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("ready", adjust_ready, e[W-1]);
            check("local_time", local_time, e[127:64]);
            check("mon_plus", mon_adjust_plus, e[63:32]);
            check("mon_minus", mon_adjust_minus, e[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit hold_v;
        bit hold_s;
        bit sv;
        bit av;
        bit as;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        set_time     = '0;
        set_valid    = 1'b0;
        adjust_sign  = 1'b0;
        adjust_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_time", local_time, 0);
        check("rst_ready", adjust_ready, 0);
        check("rst_mon_plus", mon_adjust_plus, 0);
        check("rst_mon_minus", mon_adjust_minus, 0);
        reset = 1'b1;

        // nominal rate: 10 after 3 edges, 100 after 30
        idle(30);
        check("nominal_100", local_time, 100);

        // three advance beats from 0
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("adv_13", local_time, 13);
        idle(1);

        // three retard beats from 0
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        check("ret_7", local_time, 7);
        idle(1);

        // load coincident with adjust; adjust retried on the next edge
        step(1, 64'h1000, 1, 0);
        check("load_0x1000", local_time, 64'h1000);
        step(0, 0, 1, 0);
        idle(3);

        // wrap from near all-ones
        step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        idle(1);
        check("wrap_to_1", local_time, 1);
        idle(4);

        // asynchronous reset mid-count with a pending beat
        adjust_valid = 1;
        async_reset();
        idle(6);

        // random traffic; a stalled beat keeps its sign
        hold_v = 0;
        hold_s = 0;
        for (int i = 0; i < 600; i++) begin
            sv = ($urandom_range(0, 19) == 0);
            if (hold_v) begin
                av = 1;
                as = hold_s;
            end else begin
                av = ($urandom_range(0, 2) != 0);
                as = $urandom_range(0, 1);
            end
            hold_v = av && sv;
            hold_s = as;
            step(sv, {$urandom, $urandom}, av, as);
        end
        idle(1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
